// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Runs in the PLL output clock domain, directly behind the PLL wrapper.
//   - Synchronises the raw PLL lock flag.
//   - Requires the flag to stay high for a stability window before it is trusted.
//   - Holds the design-wide reset for a few more cycles while the clock-enable
//     strobes already run, so downstream logic leaves reset with its enables
//     in phase.
//   - Counts lock losses that happen after qualification, for debug readout.
//
// Ports
//   clock           : PLL output clock; all logic uses the rising edge
//   reset           : synchronous, active-high reset
//   pll_locked      : raw PLL lock flag, asynchronous to clock
//   clear_loss      : synchronous clear of lock_loss_count
//   reset_out       : registered active-high reset for downstream logic
//   running         : registered, high while the sequencer is in RUN
//   ce              : registered single-cycle clock-enable strobes, one per channel
//   lock_loss_count : saturating count of lock losses seen in HOLD or RUN
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int NUM_CE             = 2,
  parameter int CE_DIV_WIDTH       = 8,
  parameter logic [NUM_CE*CE_DIV_WIDTH-1:0] CE_DIV = {8'd4, 8'd2}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic              clear_loss,
  output logic              reset_out,
  output logic              running,
  output logic [NUM_CE-1:0] ce,
  output logic [7:0]        lock_loss_count
);

  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES) + 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABILIZE,
    HOLD,
    RUN
  } state_t;

  state_t                  state, state_nx;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    locked_s;
  logic [STAB_W-1:0]       stab_cnt, stab_nx;
  logic [HOLD_W-1:0]       hold_cnt, hold_nx;
  logic [CE_DIV_WIDTH-1:0] div_cnt [NUM_CE];
  logic [CE_DIV_WIDTH-1:0] div_nx  [NUM_CE];
  logic [NUM_CE-1:0]       ce_nx;
  logic [7:0]              count_nx;
  logic                    loss;
  logic                    strobing, was_strobing;

  // The last synchroniser flop is the only place pll_locked is used.
  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next-state logic. The first locked cycle seen in WAIT_LOCK already counts
  // towards the stability window, which is why STABILIZE is entered with a
  // count of one (or HOLD directly when the window is a single cycle).
  always_comb begin
    state_nx = state;
    stab_nx  = stab_cnt;
    hold_nx  = hold_cnt;
    loss     = 1'b0;
    case (state)
      WAIT_LOCK: begin
        stab_nx = '0;
        hold_nx = '0;
        if (locked_s) begin
          if (LOCK_STABLE_CYCLES == 1) begin
            state_nx = HOLD;
          end else begin
            state_nx = STABILIZE;
            stab_nx  = STAB_W'(1);
          end
        end
      end
      STABILIZE: begin
        // A dropout here is only an unstable start-up, not a loss event.
        if (!locked_s) begin
          state_nx = WAIT_LOCK;
          stab_nx  = '0;
        end else if (stab_cnt == STAB_LAST) begin
          state_nx = HOLD;
          stab_nx  = '0;
        end else begin
          stab_nx = stab_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_nx = WAIT_LOCK;
          hold_nx  = '0;
          loss     = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = RUN;
          hold_nx  = '0;
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nx = WAIT_LOCK;
          loss     = 1'b1;
        end
      end
      default: begin
        state_nx = WAIT_LOCK;
        stab_nx  = '0;
        hold_nx  = '0;
      end
    endcase
  end

  // Lock-loss counter. A loss wins over a simultaneous clear, leaving the
  // count at one so that the coincident event is not lost.
  always_comb begin
    count_nx = lock_loss_count;
    if (loss) begin
      if (clear_loss) begin
        count_nx = 8'd1;
      end else if (lock_loss_count != 8'hFF) begin
        count_nx = lock_loss_count + 8'd1;
      end
    end else if (clear_loss) begin
      count_nx = '0;
    end
  end

  // Dividers start from zero on the cycle HOLD is entered, so every channel
  // strobes together there. They free-run across HOLD->RUN. A ratio of 0 or 1
  // gives a last count of 0, which makes the strobe constantly high.
  assign strobing     = (state_nx == HOLD) || (state_nx == RUN);
  assign was_strobing = (state == HOLD) || (state == RUN);

  for (genvar g = 0; g < NUM_CE; g++) begin : g_ce
    localparam logic [CE_DIV_WIDTH-1:0] RATIO = CE_DIV[g*CE_DIV_WIDTH +: CE_DIV_WIDTH];
    localparam logic [CE_DIV_WIDTH-1:0] LAST  = (RATIO == '0) ? '0 : RATIO - 1'b1;
    assign div_nx[g] = (strobing && was_strobing && (div_cnt[g] != LAST)) ?
                       div_cnt[g] + 1'b1 : '0;
    assign ce_nx[g]  = strobing && (div_nx[g] == '0);
  end

  // State register and registered outputs. The outputs are computed from the
  // next state, so they change on the same edge as the state itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q          <= '0;
      state           <= WAIT_LOCK;
      stab_cnt        <= '0;
      hold_cnt        <= '0;
      div_cnt         <= '{default: '0};
      reset_out       <= 1'b1;
      running         <= 1'b0;
      ce              <= '0;
      lock_loss_count <= '0;
    end else begin
      sync_q          <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      state           <= state_nx;
      stab_cnt        <= stab_nx;
      hold_cnt        <= hold_nx;
      div_cnt         <= div_nx;
      reset_out       <= (state_nx != RUN);
      running         <= (state_nx == RUN);
      ce              <= ce_nx;
      lock_loss_count <= count_nx;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Two sequencers share the same stimulus: "a" has two channels with ratios
//   {3,1}, "b" has four channels with ratios {0,2,5,7}. Expected output values
//   are queued against an absolute edge number when stimulus is driven, and
//   are compared on the falling edge after that rising edge.
module tb_pll_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       clear_loss;
  logic       reset_out_a, running_a;
  logic [1:0] ce_a;
  logic [7:0] count_a;
  logic       reset_out_b, running_b;
  logic [3:0] ce_b;
  logic [7:0] count_b;

  pll_reset_sequencer #(
    .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(8), .RESET_HOLD_CYCLES(4),
    .NUM_CE(2), .CE_DIV_WIDTH(8), .CE_DIV({8'd3, 8'd1})
  ) dut_a (
    .clock(clock), .reset(reset), .pll_locked(pll_locked), .clear_loss(clear_loss),
    .reset_out(reset_out_a), .running(running_a), .ce(ce_a), .lock_loss_count(count_a)
  );

  pll_reset_sequencer #(
    .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(8), .RESET_HOLD_CYCLES(4),
    .NUM_CE(4), .CE_DIV_WIDTH(8), .CE_DIV({8'd0, 8'd2, 8'd5, 8'd7})
  ) dut_b (
    .clock(clock), .reset(reset), .pll_locked(pll_locked), .clear_loss(clear_loss),
    .reset_out(reset_out_b), .running(running_b), .ce(ce_b), .lock_loss_count(count_b)
  );

  always #5 clock = ~clock;

  // Number of rising edges seen so far; edge N is the N-th rising edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Selectors: 0 reset_out (both), 1 running (both), 2 ce_a,
  // 3 lock_loss_count (both), 4 ce_b.
  typedef struct {
    int          at;
    int          sel;
    logic [31:0] exp;
    string       tag;
  } sb_item_t;

  sb_item_t sb[$];
  int total = 0;
  int bad = 0;
  int last_at = 0;
  int e0, l, r, c;

  // Scoreboard: pops every expectation that belongs to the edge just passed.
  always @(negedge clock) begin
    sb_item_t    it;
    logic [31:0] obs, want;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      it = sb.pop_front();
      total++;
      case (it.sel)
        0:       begin obs = 32'({reset_out_b, reset_out_a}); want = 32'({2{it.exp[0]}}); end
        1:       begin obs = 32'({running_b, running_a});     want = 32'({2{it.exp[0]}}); end
        2:       begin obs = 32'(ce_a);                       want = 32'(it.exp[1:0]);    end
        3:       begin obs = 32'({count_b, count_a});         want = 32'({2{it.exp[7:0]}}); end
        default: begin obs = 32'(ce_b);                       want = 32'(it.exp[3:0]);    end
      endcase
      if (it.at != cyc) obs = 32'hDEAD_BEEF;
      assert (obs === want) else begin
        bad++;
        $error("[TB] FAIL %s at edge %0d: observed=%0h expected=%0h", it.tag, cyc, obs, want);
      end
    end
  end

  // Direct comparison of every output of both sequencers against one
  // expected value set, used at points where the state is fully known.
  task automatic checkOutput(input string tag, input logic expRst, input logic expRun,
                             input logic [1:0] expCeA, input logic [3:0] expCeB,
                             input logic [7:0] expCount);
     total++;
     if (reset_out_a !== expRst || reset_out_b !== expRst) begin
        bad++;
        $display("[TB] FAIL %s_rst: observed=%b%b expected=%b", tag, reset_out_b, reset_out_a, expRst);
     end
     total++;
     if (running_a !== expRun || running_b !== expRun) begin
        bad++;
        $display("[TB] FAIL %s_run: observed=%b%b expected=%b", tag, running_b, running_a, expRun);
     end
     total++;
     if (ce_a !== expCeA) begin
        bad++;
        $display("[TB] FAIL %s_ce_a: observed=%0h expected=%0h", tag, ce_a, expCeA);
     end
     total++;
     if (ce_b !== expCeB) begin
        bad++;
        $display("[TB] FAIL %s_ce_b: observed=%0h expected=%0h", tag, ce_b, expCeB);
     end
     total++;
     if (count_a !== expCount || count_b !== expCount) begin
        bad++;
        $display("[TB] FAIL %s_count: observed=%0h/%0h expected=%0h", tag, count_a, count_b, expCount);
     end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic expect_at(input int at, input int sel, input logic [31:0] exp, input string tag);
    sb_item_t it;
    int i;
    it.at = at; it.sel = sel; it.exp = exp; it.tag = tag;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, it);
    if (at > last_at) last_at = at;
  endtask

  // Strobe pattern t cycles after HOLD entry: a channel with ratio d is high
  // whenever t is a multiple of d (ratio 0 behaves as 1).
  task automatic check_ce(input string pfx, input int start, input int n);
    logic [1:0] ea;
    logic [3:0] eb;
    for (int t = 0; t < n; t++) begin
      ea = {(t % 3 == 0), 1'b1};
      eb = {1'b1, (t % 2 == 0), (t % 5 == 0), (t % 7 == 0)};
      expect_at(start + 9 + t, 2, 32'(ea), $sformatf("%s_ce_a_t%0d", pfx, t));
      expect_at(start + 9 + t, 4, 32'(eb), $sformatf("%s_ce_b_t%0d", pfx, t));
    end
  endtask

  // Release edge is E0 + 2 + 8 + 4 - 1 = E0 + 13.
  task automatic check_release(input string pfx, input int start);
    expect_at(start + 12, 0, 1, {pfx, "_rst_before_release"});
    expect_at(start + 12, 1, 0, {pfx, "_run_before_release"});
    expect_at(start + 13, 0, 0, {pfx, "_rst_released"});
    expect_at(start + 13, 1, 1, {pfx, "_running"});
  endtask

  task automatic run_lock_sequence(input string pfx, input int start, input int n);
    expect_at(start + 8, 0, 1, {pfx, "_pre_hold_rst"});
    expect_at(start + 8, 1, 0, {pfx, "_pre_hold_run"});
    expect_at(start + 8, 2, 0, {pfx, "_pre_hold_ce_a"});
    expect_at(start + 8, 4, 0, {pfx, "_pre_hold_ce_b"});
    check_release(pfx, start);
    check_ce(pfx, start, n);
  endtask

  // Each pulse drops the lock for one cycle; the ten locked cycles after it
  // are enough to reach HOLD, so the following drop is again a loss event.
  task automatic pulse_losses(input int n);
    repeat (n) begin
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      repeat (10) tick();
    end
  endtask

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b0;
    clear_loss = 1'b0;
    repeat (3) tick();
    checkOutput("direct_reset", 1'b1, 1'b0, 2'b00, 4'b0000, 8'd0);

    // Reset values.
    expect_at(cyc + 1, 0, 1, "reset_rst");
    expect_at(cyc + 1, 1, 0, "reset_run");
    expect_at(cyc + 1, 2, 0, "reset_ce_a");
    expect_at(cyc + 1, 3, 0, "reset_count");
    expect_at(cyc + 1, 4, 0, "reset_ce_b");
    tick();

    // Clean lock: release at E0+13, strobes checked for 60 cycles from HOLD entry.
    reset      = 1'b0;
    pll_locked = 1'b1;
    e0 = cyc + 1;
    run_lock_sequence("basic", e0, 60);
    wait_until(e0 + 9 + 60);

    // Loss in RUN for three cycles, then a full re-lock.
    pll_locked = 1'b0;
    l = cyc + 1;
    expect_at(l + 1, 0, 0, "loss_still_released");
    expect_at(l + 1, 1, 1, "loss_still_running");
    expect_at(l + 2, 0, 1, "loss_rst");
    expect_at(l + 2, 1, 0, "loss_run");
    expect_at(l + 2, 2, 0, "loss_ce_a");
    expect_at(l + 2, 4, 0, "loss_ce_b");
    expect_at(l + 2, 3, 1, "loss_count");
    repeat (3) tick();
    pll_locked = 1'b1;
    e0 = cyc + 1;
    run_lock_sequence("relock", e0, 20);
    expect_at(e0 + 13, 3, 1, "relock_count");
    wait_until(e0 + 9 + 20);

    // Four more losses bring the count to five, then back into RUN.
    pulse_losses(4);
    e0 = cyc - 9;
    expect_at(cyc + 1, 3, 5, "five_losses");
    check_release("five", e0);
    expect_at(e0 + 14, 3, 5, "five_in_run");
    wait_until(e0 + 15);

    // Reset while in RUN clears everything including the loss count.
    reset = 1'b1;
    r = cyc + 1;
    expect_at(r, 0, 1, "midreset_rst");
    expect_at(r, 1, 0, "midreset_run");
    expect_at(r, 2, 0, "midreset_ce_a");
    expect_at(r, 4, 0, "midreset_ce_b");
    expect_at(r, 3, 0, "midreset_count");
    tick();
    checkOutput("direct_midreset", 1'b1, 1'b0, 2'b00, 4'b0000, 8'd0);
    reset = 1'b0;
    e0 = cyc + 1;
    run_lock_sequence("post_reset", e0, 10);
    wait_until(e0 + 9 + 10);

    // One-cycle glitch during STABILIZE: release slips by the five lost cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e0 = cyc + 1;
    expect_at(e0 + 13, 0, 1, "glitch_not_released");
    expect_at(e0 + 13, 1, 0, "glitch_not_running");
    repeat (4) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    e0 = cyc + 1;
    run_lock_sequence("glitch", e0, 10);
    expect_at(e0 + 13, 3, 0, "glitch_count");
    wait_until(e0 + 9 + 10);

    // Saturation, clear coincident with a loss, then clear alone.
    pulse_losses(260);
    expect_at(cyc + 1, 3, 255, "sat_count");
    c = cyc;
    pll_locked = 1'b0;
    expect_at(c + 2, 3, 255, "sat_before_coincident");
    expect_at(c + 3, 3, 1, "coincident_loss_clear");
    expect_at(c + 4, 3, 1, "after_coincident");
    tick();
    pll_locked = 1'b1;
    tick();
    clear_loss = 1'b1;
    tick();
    clear_loss = 1'b0;
    tick();
    expect_at(cyc + 1, 3, 0, "clear_alone");
    clear_loss = 1'b1;
    tick();
    clear_loss = 1'b0;

    wait_until(last_at + 1);
    while (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: observed=unchecked expected=%0h", sb[0].tag, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
